ula_seq: RTL and testbench
==========================

# ula_seq

Parametrised, registered N-bit ALU built as the successor to the 1-bit ULA slice. It keeps the slice's operand-invert controls and the AND/OR/ADD/SLT operation set, widened to `WIDTH` bits. It adds three things: registered flags, a start/busy/done handshake, and an iterative unsigned multiply mode. It sits between the register file read ports and the writeback stage, and the controller drives it with one command per handshake.

## Interface
- `WIDTH`, 8: operand and result width. Legal range is ≥ 2.
- `CLK` input 1: the single clock. Everything is rising-edge.
- `RST` input 1: asynchronous, active-high reset.
- `START` input 1: command strobe. Sampled only when `BUSY`=0.
- `A`, `B` input WIDTH: operands.
- `AIN`, `BIN` input 1: invert A / invert B before the operation.
- `CIN` input 1: carry-in to the adder.
- `OPERATION` input 3: operation code. 000 AND, 001 OR, 010 ADD, 011 SLT, 100 MULU, 101–111 reserved.
- `RESULT` output WIDTH: registered result.
- `COUT` output 1: registered adder carry-out.
- `OVF` output 1: registered overflow. Signed overflow for ADD/SLT; product-overflow for MULU.
- `ZERO` output 1: registered, equals `RESULT`==0.
- `BUSY` output 1: multiply in progress.
- `DONE` output 1: one-cycle pulse when `RESULT` and the flags update.

## Operation
- Operand conditioning:
  - a' = AIN ? ~A : A
  - b' = BIN ? ~B : B
  - AND, OR, ADD and SLT use a' and b'. MULU uses raw A and B; AIN, BIN and CIN are ignored for MULU.
- ADD:
  - {c, s} = a' + b' + CIN, computed at WIDTH+1 bits.
  - COUT = c.
  - OVF = (a'[W-1] == b'[W-1]) && (s[W-1] != a'[W-1]).
  - Subtract is AIN=0, BIN=1, CIN=1. NOR is AIN=1, BIN=1 with AND.
- SLT:
  - Computes the same sum as ADD.
  - RESULT = {W-1 zeros, s[W-1] ^ OVF}. This is correct signed less-than when BIN=1 and CIN=1.
  - COUT and OVF report the underlying sum.
- AND and OR: bitwise on a' and b'. COUT=0, OVF=0.
- Reserved codes: RESULT=0, COUT=0, OVF=0, ZERO=1. They complete like a single-cycle op.
- MULU: shift-add, one partial product per cycle.
  - Internal 2·WIDTH accumulator, multiplicand register and multiplier register.
  - RESULT = low WIDTH bits of the product.
  - OVF = |product[2W-1:W].
  - COUT=0.
- FSM states:
  - IDLE:
    - START with a single-cycle op: stays in IDLE, writes outputs at that edge.
    - START with MULU: goes to MUL, loads the operands, clears the accumulator and counter.
  - MUL:
    - Each edge: if multiplier LSB is 1, add the shifted multiplicand; then shift.
    - The counter increments every edge.
    - When the counter reaches WIDTH-1, the final partial product is added, outputs are written, and the FSM returns to IDLE.
- `BUSY` = (state == MUL).
- START while BUSY=1 is ignored and has no side effects.
- RESULT and all flags hold their values until the next completion.
- Reset:
  - Values: RESULT=0, COUT=0, OVF=0, ZERO=1, BUSY=0, DONE=0, state IDLE, counter 0.
  - Reset asserted mid-multiply aborts the operation immediately. No DONE is issued.
  - Reset takes effect asynchronously; deassertion is synchronous to CLK.

## Timing
- Single-cycle ops:
  - START is sampled high at edge k.
  - RESULT and the flags are valid after edge k.
  - DONE is high for the cycle after edge k. Latency is 1.
- Back-to-back single-cycle ops: START may be high on consecutive edges. Each sampled START produces its own DONE pulse.
- MULU:
  - START at edge k.
  - BUSY is high from after edge k through edge k+WIDTH.
  - RESULT is valid and DONE pulses after edge k+WIDTH. Latency is WIDTH.
  - A new START is accepted at edge k+WIDTH+1 or later.
- A, B and the control inputs only need to be stable at the edge where START is sampled. They are captured internally.

## Structure
- Package `ula_pkg`:
  - OPERATION encodings (OP_AND, OP_OR, OP_ADD, OP_SLT, OP_MULU).
  - FSM state typedef (S_IDLE, S_MUL).
- Sub-module `ula_core` holds the combinational WIDTH-bit datapath:
  - Inputs: a', b', CIN, OPERATION[1:0].
  - Outputs: result, cout, ovf.
- `ula_seq` holds the FSM, the multiplier registers and the output registers.
- Counter width is $clog2(WIDTH).

## Test plan
All scenarios use WIDTH=8.
- ADD: A=0x7F, B=0x01, CIN=0, OP=010 → RESULT=0x80, OVF=1, COUT=0, ZERO=0, DONE pulse 1 cycle after START.
- Subtract-to-zero: A=0x05, B=0x05, BIN=1, CIN=1, OP=010 → RESULT=0x00, ZERO=1, COUT=1, OVF=0.
- SLT with overflow: A=0x80, B=0x01, BIN=1, CIN=1, OP=011 → RESULT=0x01. Also A=0x01, B=0x80 → RESULT=0x00.
- NOR: A=0xF0, B=0x0F, AIN=1, BIN=1, OP=000 → RESULT=0x00, ZERO=1. Follow with A=0x00, B=0x00 → RESULT=0xFF.
- MULU: A=0x10, B=0x11, OP=100 → BUSY high 8 cycles, DONE after edge k+8, RESULT=0x10, OVF=1. A second START at k+3 is ignored. Also A=0x0F, B=0x0F → RESULT=0xE1, OVF=0.
- Reset mid-multiply: RST at iteration 4 → RESULT=0, ZERO=1, BUSY=0, no DONE. A following ADD with A=1, B=1 completes with RESULT=0x02.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: operation encodings and FSM states shared by the ula_seq slice.
package ula_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

endpackage

// File: rtl/ula_core.sv
// ula_core: combinational WIDTH-bit AND/OR/ADD/SLT datapath on pre-conditioned operands.
module ula_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] slt;

    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // Sign of the difference corrected by overflow gives signed less-than.
    assign slt     = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};

    always_comb begin
        result = op == 2'b00 ? (a & b) :
                 op == 2'b01 ? (a | b) :
                 op == 2'b10 ? sum[WIDTH-1:0] : slt;
        cout   = op[1] && sum[WIDTH];
        ovf    = op[1] && add_ovf;
    end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: registered N-bit ALU with start/busy/done handshake and iterative unsigned multiply.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ain,
    input  logic             bin,
    input  logic             cin,
    input  logic [2:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc, mcand, prod;
    logic [WIDTH-1:0]   mplier, ac, bc, core_res;
    logic [CW-1:0]      cnt;
    logic               core_cout, core_ovf, go, go_mul, last;

    assign ac     = ain ? ~a : a;
    assign bc     = bin ? ~b : b;
    assign go     = start && state == S_IDLE;
    assign go_mul = go && operation == OP_MULU;
    assign last   = state == S_MUL && cnt == CW'(WIDTH - 1);
    assign prod   = acc + (mplier[0] ? mcand : '0);
    assign busy   = state == S_MUL;

    ula_core #(.WIDTH(WIDTH)) u_core (
        .a      (ac),
        .b      (bc),
        .cin    (cin),
        .op     (operation[1:0]),
        .result (core_res),
        .cout   (core_cout),
        .ovf    (core_ovf)
    );

    always_comb begin
        state_nx = go_mul ? S_MUL : last ? S_IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go_mul) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= '0;
            end else if (go) begin
                // Reserved codes (op[2] set, not MULU) complete with an all-zero result.
                result <= operation[2] ? '0 : core_res;
                cout   <= !operation[2] && core_cout;
                ovf    <= !operation[2] && core_ovf;
                zero   <= operation[2] || core_res == '0;
                done   <= 1'b1;
            end else if (busy) begin
                acc    <= prod;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    result <= prod[WIDTH-1:0];
                    cout   <= 1'b0;
                    ovf    <= |prod[2*WIDTH-1:WIDTH];
                    zero   <= prod[WIDTH-1:0] == '0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: table-driven checks of single-cycle ops plus directed multiply, back-to-back and reset sequences.
module tb_ula_seq;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       ain = 1'b0, bin = 1'b0, cin = 1'b0;
    logic [2:0] operation = '0;
    logic [7:0] result;
    logic       cout, ovf, zero, busy, done;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        logic [7:0] a, b;
        logic       ain, bin, cin;
        logic [2:0] op;
        logic [7:0] res;
        logic       cout, ovf, zero;
    } vec_t;

    vec_t vt[11];

    ula_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ain(ain), .bin(bin),
        .cin(cin), .operation(operation), .result(result), .cout(cout), .ovf(ovf),
        .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] va, vb, input logic vai, vbi, vci, input logic [2:0] vop);
        a = va; b = vb; ain = vai; bin = vbi; cin = vci; operation = vop; start = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.a, v.b, v.ain, v.bin, v.cin, v.op);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d result", idx), 16'(result), 16'(v.res));
        chk($sformatf("v%0d cout", idx), 16'(cout), 16'(v.cout));
        chk($sformatf("v%0d ovf", idx), 16'(ovf), 16'(v.ovf));
        chk($sformatf("v%0d zero", idx), 16'(zero), 16'(v.zero));
        chk($sformatf("v%0d done", idx), 16'(done), 16'd1);
        @(negedge clk);
        chk($sformatf("v%0d done_drop", idx), 16'(done), 16'd0);
        chk($sformatf("v%0d hold", idx), 16'(result), 16'(v.res));
    endtask

    task automatic mul_run(input logic [7:0] va, vb, input logic [7:0] er, input logic eo, input logic interfere);
        int nb, nd, de;
        logic [7:0] r_at;
        logic o_at;
        nb = 0; nd = 0; de = -1; r_at = '0; o_at = 1'b0;
        @(negedge clk);
        drive(va, vb, 1'b1, 1'b1, 1'b1, 3'b100);
        @(negedge clk);
        start = 1'b0;
        if (busy) nb++;
        for (int e = 1; e <= 12; e++) begin
            if (interfere && e == 3) drive(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'b010);
            @(negedge clk);
            start = 1'b0;
            if (busy) nb++;
            if (done) begin
                nd++; de = e; r_at = result; o_at = ovf;
                chk("mul busy_at_done", 16'(busy), 16'd0);
                chk("mul zero", 16'(zero), 16'(er == 8'h00));
                chk("mul cout", 16'(cout), 16'd0);
            end
        end
        chk("mul busy_cycles", 16'(nb), 16'd8);
        chk("mul done_count", 16'(nd), 16'd1);
        chk("mul done_edge", 16'(de), 16'd8);
        chk("mul result", 16'(r_at), 16'(er));
        chk("mul ovf", 16'(o_at), 16'(eo));
        chk("mul result_held", 16'(result), 16'(er));
    endtask

    initial begin
        vt[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 3'b010, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 3'b011, 8'h01, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{8'h12, 8'h40, 1'b0, 1'b0, 1'b0, 3'b001, 8'h52, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{8'hF3, 8'h3C, 1'b0, 1'b0, 1'b0, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[10] = '{8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 3'b010, 8'h00, 1'b1, 1'b1, 1'b1};

        #12;
        chk("rst result", 16'(result), 16'h00);
        chk("rst zero", 16'(zero), 16'd1);
        chk("rst flags", {14'd0, cout, ovf}, 16'd0);
        chk("rst busy_done", {14'd0, busy, done}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vt[i], i);

        @(negedge clk);
        drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 3'b010);
        @(negedge clk);
        chk("b2b first", 16'(result), 16'h03);
        chk("b2b first_done", 16'(done), 16'd1);
        drive(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 3'b001);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second", 16'(result), 16'hFF);
        chk("b2b second_done", 16'(done), 16'd1);
        @(negedge clk);
        chk("b2b done_drop", 16'(done), 16'd0);

        mul_run(8'h10, 8'h11, 8'h10, 1'b1, 1'b1);
        mul_run(8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0);

        @(negedge clk);
        drive(8'h10, 8'h11, 1'b0, 1'b0, 1'b0, 3'b100);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy_before", 16'(busy), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort result", 16'(result), 16'h00);
        chk("abort zero", 16'(zero), 16'd1);
        chk("abort busy", 16'(busy), 16'd0);
        chk("abort done", 16'(done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort no_done", {15'd0, done}, 16'd0);
        end
        @(negedge clk);
        drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 3'b010);
        @(negedge clk);
        start = 1'b0;
        chk("post_abort add", 16'(result), 16'h02);
        chk("post_abort done", 16'(done), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
